// File: rtl/mux_sequencer.sv
// Column multiplexer sequencer for a rotating LED display.
// Selects one column at a time from the current hall slice index. Every column
// switch passes through an all-off dead period. Queued driver reconfiguration
// requests are honoured inside that dead period.
module mux_sequencer #(
  parameter int unsigned DEAD_TIME = 4,
  parameter int unsigned NB_COLS   = 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [7:0]         slice_cnt,
  input  logic               driver_ready,
  input  logic               column_ready,
  input  logic               conf_req,
  output logic [NB_COLS-1:0] mul_sel,
  output logic               position_sync,
  output logic               new_configuration_ready,
  output logic               conf_pending,
  output logic [7:0]         underrun_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StDead,
    StConf
  } state_t;

  localparam logic [7:0] DeadLast = 8'(DEAD_TIME - 1);

  state_t               state;
  logic   [7:0]         slice_q;
  logic   [7:0]         dead_cnt;
  logic                 col_flag;
  logic                 slice_event;
  int unsigned          col;
  logic   [NB_COLS-1:0] col_onehot;

  // Slice change detect and the one-hot column for the registered slice.
  // Slice k lights column k-1, slice 0 wraps to the last column.
  always_comb begin
    slice_event = (slice_cnt != slice_q);
    col         = (32'(slice_q) + NB_COLS - 1) % NB_COLS;
    col_onehot  = '0;
    for (int unsigned i = 0; i < NB_COLS; i++) begin
      col_onehot[i] = (i == col);
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state                   <= StIdle;
      slice_q                 <= slice_cnt;
      dead_cnt                <= 8'd0;
      col_flag                <= 1'b0;
      mul_sel                 <= '0;
      position_sync           <= 1'b0;
      new_configuration_ready <= 1'b0;
      conf_pending            <= 1'b0;
      underrun_cnt            <= 8'd0;
    end else begin
      slice_q                 <= slice_cnt;
      position_sync           <= 1'b0;
      new_configuration_ready <= 1'b0;

      case (state)
        StIdle: begin
          mul_sel <= '0;
          if (driver_ready) begin
            state         <= StOn;
            mul_sel       <= col_onehot;
            position_sync <= 1'b1;
            col_flag      <= 1'b0;
          end
        end

        StOn: begin
          if (!driver_ready) begin
            // Driver dropped out: not an underrun, just stop displaying.
            state   <= StIdle;
            mul_sel <= '0;
          end else if (slice_event) begin
            state    <= StDead;
            mul_sel  <= '0;
            dead_cnt <= 8'd0;
            // A column_ready arriving with the slice change still counts.
            if (!col_flag && !column_ready && underrun_cnt != 8'hFF) begin
              underrun_cnt <= underrun_cnt + 8'd1;
            end
          end else begin
            mul_sel <= col_onehot;
            if (column_ready) begin
              col_flag <= 1'b1;
            end
          end
        end

        StDead: begin
          mul_sel <= '0;
          if (slice_event) begin
            // Another slice change: the full dead time starts over.
            dead_cnt <= 8'd0;
          end else if (dead_cnt >= DeadLast) begin
            dead_cnt <= 8'd0;
            if (conf_pending) begin
              state                   <= StConf;
              new_configuration_ready <= 1'b1;
              conf_pending            <= 1'b0;
            end else begin
              state         <= StOn;
              mul_sel       <= col_onehot;
              position_sync <= 1'b1;
              col_flag      <= 1'b0;
            end
          end else begin
            dead_cnt <= dead_cnt + 8'd1;
          end
        end

        StConf: begin
          mul_sel <= '0;
          if (driver_ready) begin
            state         <= StOn;
            mul_sel       <= col_onehot;
            position_sync <= 1'b1;
            col_flag      <= 1'b0;
          end
        end

        default: begin
          state   <= StIdle;
          mul_sel <= '0;
        end
      endcase

      // Placed after the FSM so a request in the clearing cycle stays queued.
      if (conf_req) begin
        conf_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_sequencer.sv
// Directed testbench for mux_sequencer with hand-computed expectations.
module tb_mux_sequencer;

  logic       clk;
  logic       nrst;
  logic [7:0] slice_cnt;
  logic       driver_ready;
  logic       column_ready;
  logic       conf_req;
  logic [7:0] mul_sel;
  logic       position_sync;
  logic       new_configuration_ready;
  logic       conf_pending;
  logic [7:0] underrun_cnt;

  int checks = 0;
  int errors = 0;

  mux_sequencer #(
    .DEAD_TIME(4),
    .NB_COLS  (8)
  ) dut (
    .clk                    (clk),
    .nrst                   (nrst),
    .slice_cnt              (slice_cnt),
    .driver_ready           (driver_ready),
    .column_ready           (column_ready),
    .conf_req               (conf_req),
    .mul_sel                (mul_sel),
    .position_sync          (position_sync),
    .new_configuration_ready(new_configuration_ready),
    .conf_pending           (conf_pending),
    .underrun_cnt           (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst         = 1'b0;
    slice_cnt    = 8'd0;
    driver_ready = 1'b0;
    column_ready = 1'b0;
    conf_req     = 1'b0;
    step();
    step();
    check("rst_mul_sel", 32'(mul_sel), 32'h00);
    check("rst_psync", 32'(position_sync), 0);
    check("rst_ncr", 32'(new_configuration_ready), 0);
    check("rst_pending", 32'(conf_pending), 0);
    check("rst_underrun", 32'(underrun_cnt), 0);

    // Reset release with driver ready, slice 0 -> last column.
    nrst         = 1'b1;
    driver_ready = 1'b1;
    step();
    check("on_mul_sel", 32'(mul_sel), 32'h80);
    check("on_psync", 32'(position_sync), 1);
    step();
    check("on_psync_low", 32'(position_sync), 0);
    check("on_mul_hold", 32'(mul_sel), 32'h80);

    // Slice 0 -> 1 with no column_ready: 4 dead cycles then column 0.
    slice_cnt = 8'd1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("dead1_%0d", i), 32'(mul_sel), 32'h00);
    end
    check("underrun_1", 32'(underrun_cnt), 1);
    step();
    check("col0_mul_sel", 32'(mul_sel), 32'h01);
    check("col0_psync", 32'(position_sync), 1);

    // Column data latched, two conf requests absorbed into one.
    column_ready = 1'b1;
    step();
    column_ready = 1'b0;
    conf_req     = 1'b1;
    step();
    conf_req = 1'b0;
    step();
    conf_req = 1'b1;
    step();
    conf_req = 1'b0;
    check("pending_set", 32'(conf_pending), 1);
    slice_cnt = 8'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("dead2_mul_%0d", i), 32'(mul_sel), 32'h00);
      check($sformatf("dead2_ncr_%0d", i), 32'(new_configuration_ready), 0);
    end
    check("no_underrun_ready", 32'(underrun_cnt), 1);
    step();
    check("conf_ncr", 32'(new_configuration_ready), 1);
    check("conf_pending_clr", 32'(conf_pending), 0);
    check("conf_mul_sel", 32'(mul_sel), 32'h00);
    driver_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("conf_wait_mul_%0d", i), 32'(mul_sel), 32'h00);
      check($sformatf("conf_wait_ncr_%0d", i), 32'(new_configuration_ready), 0);
    end
    driver_ready = 1'b1;
    step();
    check("conf_exit_mul", 32'(mul_sel), 32'h02);
    check("conf_exit_psync", 32'(position_sync), 1);

    // Slice change 2 cycles into DEAD restarts the dead period: 6 zero cycles.
    slice_cnt = 8'd3;
    step();
    check("restart_mul_0", 32'(mul_sel), 32'h00);
    step();
    check("restart_mul_1", 32'(mul_sel), 32'h00);
    slice_cnt = 8'd4;
    for (int i = 2; i < 6; i++) begin
      step();
      check($sformatf("restart_mul_%0d", i), 32'(mul_sel), 32'h00);
    end
    step();
    check("restart_exit_mul", 32'(mul_sel), 32'h08);
    check("restart_exit_psync", 32'(position_sync), 1);
    check("underrun_2", 32'(underrun_cnt), 2);

    // Driver drop in ON goes idle without counting an underrun.
    driver_ready = 1'b0;
    step();
    check("idle_mul", 32'(mul_sel), 32'h00);
    check("idle_underrun", 32'(underrun_cnt), 2);
    driver_ready = 1'b1;
    step();
    check("idle_exit_mul", 32'(mul_sel), 32'h08);
    check("idle_exit_psync", 32'(position_sync), 1);

    // 300 slice changes without column_ready saturate the underrun counter.
    for (int i = 0; i < 300; i++) begin
      slice_cnt = slice_cnt + 8'd1;
      for (int j = 0; j < 5; j++) step();
    end
    check("underrun_sat", 32'(underrun_cnt), 255);
    check("sat_mul_sel", 32'(mul_sel), 32'h80);
    driver_ready = 1'b0;
    step();
    check("sat_idle_mul", 32'(mul_sel), 32'h00);
    check("sat_idle_underrun", 32'(underrun_cnt), 255);
    driver_ready = 1'b1;
    step();
    check("sat_on_mul", 32'(mul_sel), 32'h80);

    // Reset in the cycle before CONF entry drops the queued request.
    conf_req = 1'b1;
    step();
    conf_req = 1'b0;
    check("pending_again", 32'(conf_pending), 1);
    slice_cnt = 8'd49;
    for (int i = 0; i < 4; i++) step();
    nrst = 1'b0;
    step();
    check("abort_ncr", 32'(new_configuration_ready), 0);
    check("abort_pending", 32'(conf_pending), 0);
    check("abort_mul", 32'(mul_sel), 32'h00);
    check("abort_psync", 32'(position_sync), 0);
    check("abort_underrun", 32'(underrun_cnt), 0);
    nrst = 1'b1;
    step();
    check("post_rst_mul", 32'(mul_sel), 32'h01);
    check("post_rst_psync", 32'(position_sync), 1);
    check("post_rst_ncr", 32'(new_configuration_ready), 0);
    check("post_rst_pending", 32'(conf_pending), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
